aemb_intc: RTL

- Wishbone-slave interrupt controller that drives the single CPU interrupt line, sys_int_o, into the aeMB core's sys_int_i.
- Collects NSRC external interrupt sources and latches their rising edges into a pending register.
- Masks the pending bits per source and under a master enable.
- Shapes the CPU line so every new interrupt is a clean low-then-high edge, as the core's positive-edge interrupt latch requires.
- Sits on the data Wishbone bus beside other aeMB peripherals.

---
 rtl/aemb_intc_pkg.sv | 20 ++
 rtl/aemb_intc_if.sv | 14 +
 rtl/aemb_intc_sync.sv | 39 +++
 rtl/aemb_intc.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/aemb_intc_pkg.sv
// Shared definitions for the aeMB interrupt controller: register offsets, output FSM
// encoding and the vector returned when no enabled interrupt is pending.
package aemb_intc_pkg;

  typedef enum logic [1:0] {
    REG_ISR = 2'd0,
    REG_IER = 2'd1,
    REG_IAR = 2'd2,
    REG_IVR = 2'd3
  } reg_addr_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  localparam logic [31:0] NO_IRQ_VECTOR = 32'hFFFF_FFFF;

endpackage

// File: rtl/aemb_intc_if.sv
// Wishbone slave bus bundle for the interrupt controller; _i/_o are named from the slave's side.
interface aemb_intc_if;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [1:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport slave  (input  wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
                  output wb_dat_o, wb_ack_o);
  modport master (output wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
                  input  wb_dat_o, wb_ack_o);
endinterface

// File: rtl/aemb_intc_sync.sv
// Per-bit 2-flop synchroniser. evt_o is a one-cycle rising-edge pulse, or the
// synchronised level when AEMB_INTC_LEVEL_EN is defined (edge-delay flops dropped).
module aemb_intc_sync #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] evt_o
);

  logic [W-1:0] s1_q, s2_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain a shift.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

`ifdef AEMB_INTC_LEVEL_EN
  assign evt_o = s2_q;
`else
  logic [W-1:0] dly_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) dly_q <= '0;
    else       dly_q <= s2_q;
  end

  assign evt_o = s2_q & ~dly_q;
`endif

endmodule

// File: rtl/aemb_intc.sv
// aeMB Wishbone interrupt controller: pending/enable/ack registers plus an output FSM that
// guarantees a low gap before every assertion of sys_int_o. Option: AEMB_INTC_LEVEL_EN.
module aemb_intc
  import aemb_intc_pkg::*;
#(
  parameter int NSRC = 8,
  parameter int GAP  = 3
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  input  logic [NSRC-1:0] int_src_i,
  aemb_intc_if.slave      bus,
  output logic            sys_int_o
);

  function automatic logic [31:0] zext(input logic [NSRC-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NSRC-1:0] = v;
    return r;
  endfunction

  function automatic logic [4:0] lowest_idx(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) if (v[i]) idx = 5'(i);
    return idx;
  endfunction

  logic            ack_q;
  logic [31:0]     dat_q, dat_d;
  logic [NSRC-1:0] isr_q, isr_d, ier_q, ier_d;
  logic            mer_q, mer_d;
  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            int_q;

  logic [NSRC-1:0] evt, isr, isr_set, iar_clr, pend;
  logic            access, iar_wr, act;
  logic [31:0]     ivr;
  logic            unused_dat;

  aemb_intc_sync #(.W(NSRC)) u_sync (
    .clk_i (sys_clk_i),
    .rst_i (sys_rst_i),
    .d_i   (int_src_i),
    .evt_o (evt)
  );

  // In level mode isr_q holds only the software-set component.
`ifdef AEMB_INTC_LEVEL_EN
  assign isr   = evt | isr_q;
  assign isr_d = (isr_q & ~iar_clr) | isr_set;
`else
  assign isr   = isr_q;
  assign isr_d = (isr_q & ~iar_clr) | isr_set | evt;
`endif

  assign access     = bus.wb_stb_i & ~ack_q;
  assign pend       = isr & ier_q;
  assign act        = mer_q & (|pend);
  assign ivr        = (|pend) ? {act, 26'b0, lowest_idx(zext(pend))} : NO_IRQ_VECTOR;
  assign unused_dat = ^bus.wb_dat_i;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    dat_d   = dat_q;
    ier_d   = ier_q;
    mer_d   = mer_q;
    isr_set = '0;
    iar_clr = '0;
    iar_wr  = 1'b0;
    if (access) begin
      case (reg_addr_e'(bus.wb_adr_i))
        REG_ISR: begin
          dat_d = zext(isr);
          if (bus.wb_we_i) isr_set = bus.wb_dat_i[NSRC-1:0];
        end
        REG_IER: begin
          dat_d = zext(ier_q);
          if (bus.wb_we_i) ier_d = bus.wb_dat_i[NSRC-1:0];
        end
        REG_IAR: begin
          dat_d = '0;
          if (bus.wb_we_i) begin
            iar_wr  = 1'b1;
            iar_clr = bus.wb_dat_i[NSRC-1:0];
          end
        end
        default: begin
          dat_d = ivr;
          if (bus.wb_we_i) mer_d = bus.wb_dat_i[0];
        end
      endcase
    end
  end

  // Re-asserting straight from the last gap cycle keeps the low time exactly GAP cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:   if (act) state_d = ST_ASSERT;
      ST_ASSERT: if (iar_wr || !act) begin
                   state_d = ST_GAP;
                   cnt_d   = 4'(GAP - 1);
                 end
      ST_GAP:    if (cnt_q == 4'd0) state_d = act ? ST_ASSERT : ST_IDLE;
                 else               cnt_d   = cnt_q - 4'd1;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      isr_q   <= '0;
      ier_q   <= '0;
      mer_q   <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      int_q   <= 1'b0;
    end else begin
      ack_q   <= access;
      dat_q   <= dat_d;
      isr_q   <= isr_d;
      ier_q   <= ier_d;
      mer_q   <= mer_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      int_q   <= (state_d == ST_ASSERT);
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = dat_q;
  assign sys_int_o    = int_q;

endmodule
